// File: rtl/mc_defines.sv
// Shared encodings for the multi-cycle control unit: states, instruction fields,
// ALU operations, datapath select codes and trap causes.
package mc_defines;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_WB_I     = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;
  localparam logic [3:0] S_ERROR    = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_REG = 2'd1;

  localparam logic [1:0] SRCB_FOUR   = 2'd0;
  localparam logic [1:0] SRCB_REG    = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state and flags the
// cycle in which the count would reach WAIT_MAX without a ready.
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int TW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  logic [TW-1:0] cnt_q;

  // A ready in the last allowed cycle wins over the timeout.
  assign expired = waiting && !ready && (cnt_q == TW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!waiting || ready || clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/writeback,
// traps illegal instructions and memory timeouts, and keeps saturating counters.
module mc_control_fsm
  import mc_defines::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_data_write,
  output logic                alu_out_write,
  output logic                mem_data_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          state,
  output logic                halted,
  output logic [1:0]          trap,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    inst_count
);

  logic [3:0]       state_q, state_d;
  logic [1:0]       trap_q;
  logic             halted_q;
  logic [CNT_W-1:0] cycle_q, inst_q;
  logic [3:0]       alu_op_c, funct_alu;
  logic             is_r, is_lw, is_sw, is_addi, is_beq, is_j, is_halt;
  logic             op_legal, funct_legal, insn_legal;
  logic             waiting, wait_ready, leaving, expired, retire, frozen;

  assign is_r    = (opcode == OPCODE_W'(OP_RTYPE));
  assign is_lw   = (opcode == OPCODE_W'(OP_LW));
  assign is_sw   = (opcode == OPCODE_W'(OP_SW));
  assign is_addi = (opcode == OPCODE_W'(OP_ADDI));
  assign is_beq  = (opcode == OPCODE_W'(OP_BEQ));
  assign is_j    = (opcode == OPCODE_W'(OP_J));
  assign is_halt = (opcode == OPCODE_W'(OP_HALT));
  assign op_legal = is_r | is_lw | is_sw | is_addi | is_beq | is_j | is_halt;

  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      FUNCT_W'(FN_ADD): funct_alu = ALU_ADD;
      FUNCT_W'(FN_SUB): funct_alu = ALU_SUB;
      FUNCT_W'(FN_AND): funct_alu = ALU_AND;
      FUNCT_W'(FN_OR):  funct_alu = ALU_OR;
      FUNCT_W'(FN_SLT): funct_alu = ALU_SLT;
      default:          funct_legal = 1'b0;
    endcase
  end

  // Instructions that will trap never load A/B or ALU-out, even in DECODE.
  assign insn_legal = op_legal && (!is_r || funct_legal);

  assign waiting    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  assign leaving    = (state_d != state_q);

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ready   (wait_ready),
    .clear   (leaving),
    .expired (expired)
  );

  always_comb begin
    state_d        = state_q;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    reg_data_write = 1'b0;
    alu_out_write  = 1'b0;
    mem_data_write = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    alu_src_a      = SRCA_PC;
    alu_src_b      = SRCB_FOUR;
    pc_src         = PCSRC_ALU;
    alu_op_c       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (expired) begin
          state_d = S_ERROR;
        end else if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        reg_data_write = insn_legal;
        alu_out_write  = insn_legal;
        alu_src_b      = SRCB_IMM_SH;
        if (is_r)               state_d = S_EXEC_R;
        else if (is_lw | is_sw) state_d = S_MEM_ADDR;
        else if (is_addi)       state_d = S_EXEC_I;
        else if (is_beq)        state_d = S_BRANCH;
        else if (is_j)          state_d = S_JUMP;
        else if (is_halt)       state_d = S_HALT;
        else                    state_d = S_ERROR;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op_c  = funct_alu;
        if (funct_legal) begin
          alu_out_write = 1'b1;
          state_d       = S_WB_R;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a     = SRCA_REG;
        alu_src_b     = SRCB_IMM;
        alu_out_write = 1'b1;
        if (state_q == S_EXEC_I) state_d = S_WB_I;
        else                     state_d = is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        if (expired) begin
          state_d = S_ERROR;
        end else if (dmem_ready) begin
          mem_data_write = 1'b1;
          state_d        = S_WB_MEM;
        end
      end
      S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (expired)         state_d = S_ERROR;
        else if (dmem_ready) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op_c  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT, S_ERROR: ;
      default: state_d = S_ERROR;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_op_c);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR: retire = (state_d == S_FETCH);
      S_DECODE: retire = (state_d == S_HALT);
      default:  retire = 1'b0;
    endcase
  end

  assign frozen = (state_q == S_HALT) || (state_q == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      trap_q   <= TRAP_NONE;
      halted_q <= 1'b0;
      cycle_q  <= '0;
      inst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ERROR && state_q != S_ERROR)
        trap_q <= expired ? TRAP_TIMEOUT : TRAP_ILLEGAL;
      if (state_d == S_HALT || state_d == S_ERROR)
        halted_q <= 1'b1;
      if (!frozen && cycle_q != '1)
        cycle_q <= cycle_q + 1'b1;
      if (retire && inst_q != '1)
        inst_q <= inst_q + 1'b1;
    end
  end

  assign state       = state_q;
  assign trap        = trap_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus random
// instruction streams scripted cycle by cycle from the instruction semantics.
module tb_mc_control_fsm;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  localparam logic [3:0] T_FETCH = 0, T_DECODE = 1, T_EXEC_R = 2, T_EXEC_I = 3,
                         T_MEM_ADDR = 4, T_MEM_RD = 5, T_MEM_WR = 6, T_WB_R = 7,
                         T_WB_I = 8, T_WB_MEM = 9, T_BRANCH = 10, T_JUMP = 11,
                         T_HALT = 12, T_ERROR = 13;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_ADDI = 6'b001000, O_BEQ = 6'b000100, O_J = 6'b000010,
                         O_HALT = 6'b111111;

  // Expected control vector: strobes in the top bits, then a, b, pc_src, alu_op.
  localparam logic [20:0] B_IMREQ = 21'h100000, B_DMREQ = 21'h080000, B_WE  = 21'h040000,
                          B_PCW   = 21'h020000, B_IRW   = 21'h010000, B_RDW = 21'h008000,
                          B_AOW   = 21'h004000, B_MDW   = 21'h002000, B_RW  = 21'h001000,
                          B_RDST  = 21'h000800, B_M2R   = 21'h000400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, pc_write, ir_write, reg_data_write, alu_out_write;
  logic mem_data_write, reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] alu_src_a, alu_src_b, pc_src, trap;
  logic [3:0] alu_op, state;
  logic [CNT_W-1:0] cycle_count, inst_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cyc = 0;
  int exp_inst = 0;
  logic [1:0] cur_trap = 2'd0;

  always #5 clk = ~clk;

  mc_control_fsm #(
    .OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .ir_write(ir_write), .reg_data_write(reg_data_write),
    .alu_out_write(alu_out_write), .mem_data_write(mem_data_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op), .state(state), .halted(halted), .trap(trap),
    .cycle_count(cycle_count), .inst_count(inst_count)
  );

  wire [20:0] dut_ctl = {imem_req, dmem_req, dmem_we, pc_write, ir_write, reg_data_write,
                         alu_out_write, mem_data_write, reg_write, reg_dst, mem_to_reg,
                         alu_src_a, alu_src_b, pc_src, alu_op};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [20:0] sel(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] p, input logic [3:0] o);
    return {11'b0, a, b, p, o};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn, output logic [3:0] aop);
    aop = 4'd0;
    case (fn)
      6'b100000: aop = 4'd0;
      6'b100010: aop = 4'd1;
      6'b100100: aop = 4'd2;
      6'b100101: aop = 4'd3;
      6'b101010: aop = 4'd4;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op == O_R || op == O_LW || op == O_SW || op == O_ADDI ||
           op == O_BEQ || op == O_J || op == O_HALT;
  endfunction

  // One clock cycle: drive inputs, check every output at the falling edge, advance the model.
  task automatic step(input logic [3:0] st, input bit imr, input bit dmr, input bit z,
                      input logic [20:0] ctl, input bit ret);
    bit stopped;
    imem_ready = imr;
    dmem_ready = dmr;
    zero = z;
    stopped = (st == T_HALT) || (st == T_ERROR);
    @(negedge clk);
    check("state", state, st);
    check("ctl", dut_ctl, ctl);
    check("trap", trap, cur_trap);
    check("halted", halted, stopped);
    check("cycle_count", cycle_count, exp_cyc);
    check("inst_count", inst_count, exp_inst);
    if (!stopped && exp_cyc < CMAX) exp_cyc++;
    if (ret && exp_inst < CMAX) exp_inst++;
    @(posedge clk);
    #1;
  endtask

  task automatic stuck(input int n);
    for (int i = 0; i < n; i++)
      step((cur_trap != 2'd0) ? T_ERROR : T_HALT, rb(), rb(), rb(), 21'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_state", state, T_FETCH);
    check("rst_imem_req", imem_req, 1'b1);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_cycle", cycle_count, 0);
    check("rst_inst", inst_count, 0);
    check("rst_trap", trap, 0);
    check("rst_halted", halted, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cyc = 0;
    exp_inst = 0;
    cur_trap = 2'd0;
  endtask

  // fw/dw: number of not-ready cycles before the fetch / data access completes.
  task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input int fw,
                          input int dw, input bit z, output bit dead);
    logic [3:0] aop;
    logic [3:0] mst;
    logic [20:0] mctl;
    bit fok, known, sw;
    dead = 1'b0;
    opcode = op;
    funct = fn;
    fok = funct_ok(fn, aop);
    known = op_known(op);
    for (int i = 0; i < fw && i < WAIT_MAX; i++) step(T_FETCH, 1'b0, rb(), rb(), B_IMREQ, 1'b0);
    if (fw >= WAIT_MAX) begin
      cur_trap = 2'd2;
      stuck(3);
      dead = 1'b1;
      return;
    end
    step(T_FETCH, 1'b1, rb(), rb(), B_IMREQ | B_PCW | B_IRW, 1'b0);
    step(T_DECODE, rb(), rb(), rb(),
         sel(2'd0, 2'd3, 2'd0, 4'd0) | ((known && (op != O_R || fok)) ? (B_RDW | B_AOW) : 21'd0),
         op == O_HALT);
    if (!known) cur_trap = 2'd1;
    if (!known || op == O_HALT) begin
      stuck(3);
      dead = 1'b1;
      return;
    end
    case (op)
      O_R: begin
        if (fok) begin
          step(T_EXEC_R, rb(), rb(), rb(), sel(2'd1, 2'd1, 2'd0, aop) | B_AOW, 1'b0);
          step(T_WB_R, rb(), rb(), rb(), B_RW | B_RDST, 1'b1);
        end else begin
          step(T_EXEC_R, rb(), rb(), rb(), sel(2'd1, 2'd1, 2'd0, 4'd0), 1'b0);
          cur_trap = 2'd1;
          stuck(3);
          dead = 1'b1;
        end
      end
      O_ADDI: begin
        step(T_EXEC_I, rb(), rb(), rb(), sel(2'd1, 2'd2, 2'd0, 4'd0) | B_AOW, 1'b0);
        step(T_WB_I, rb(), rb(), rb(), B_RW, 1'b1);
      end
      O_LW, O_SW: begin
        sw = (op == O_SW);
        mst = sw ? T_MEM_WR : T_MEM_RD;
        mctl = sw ? (B_DMREQ | B_WE) : B_DMREQ;
        step(T_MEM_ADDR, rb(), rb(), rb(), sel(2'd1, 2'd2, 2'd0, 4'd0) | B_AOW, 1'b0);
        for (int i = 0; i < dw && i < WAIT_MAX; i++) step(mst, rb(), 1'b0, rb(), mctl, 1'b0);
        if (dw >= WAIT_MAX) begin
          cur_trap = 2'd2;
          stuck(3);
          dead = 1'b1;
        end else begin
          step(mst, rb(), 1'b1, rb(), sw ? mctl : (mctl | B_MDW), sw);
          if (!sw) step(T_WB_MEM, rb(), rb(), rb(), B_RW | B_M2R, 1'b1);
        end
      end
      O_BEQ: step(T_BRANCH, rb(), rb(), z, sel(2'd1, 2'd1, 2'd1, 4'd1) | (z ? B_PCW : 21'd0), 1'b1);
      default: step(T_JUMP, rb(), rb(), rb(), sel(2'd0, 2'd0, 2'd2, 4'd0) | B_PCW, 1'b1);
    endcase
  endtask

  function automatic int pick_wait(input bit allow_trap);
    int r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 90) return $urandom_range(1, 4);
    if (r < 95 || !allow_trap) return WAIT_MAX - 1;
    return WAIT_MAX;
  endfunction

  task automatic random_insn(input bit allow_trap, output bit dead);
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    int r = $urandom_range(0, allow_trap ? 99 : 92);
    fn = legal_fn[$urandom_range(0, 4)];
    if (r < 30) begin
      op = O_R;
      if (allow_trap && $urandom_range(0, 9) == 0) fn = 6'($urandom);
    end
    else if (r < 45) op = O_LW;
    else if (r < 60) op = O_SW;
    else if (r < 72) op = O_ADDI;
    else if (r < 84) op = O_BEQ;
    else if (r < 93) op = O_J;
    else if (r < 96) op = O_HALT;
    else begin
      op = 6'($urandom);
      while (op_known(op)) op = 6'($urandom);
    end
    run_insn(op, fn, pick_wait(allow_trap), pick_wait(allow_trap), rb(), dead);
  endtask

  initial begin
    bit dead;
    @(posedge clk);
    #1;
    do_reset();

    run_insn(O_R, 6'b100000, 0, 0, 1'b0, dead);
    check("add_inst_after_4", inst_count, 1);
    check("add_cycles", cycle_count, 4);

    do_reset();
    run_insn(O_LW, 6'd0, 0, 3, 1'b0, dead);
    check("lw_cycles", cycle_count, 8);

    run_insn(O_BEQ, 6'd0, 0, 0, 1'b1, dead);
    run_insn(O_BEQ, 6'd0, 1, 0, 1'b0, dead);
    check("beq_inst", inst_count, 3);

    do_reset();
    run_insn(O_R, 6'b100000, WAIT_MAX, 0, 1'b0, dead);
    check("timeout_trap", trap, 2);
    check("timeout_imem_req", imem_req, 1'b0);
    check("timeout_cycle_frozen", cycle_count, WAIT_MAX);

    do_reset();
    run_insn(O_ADDI, 6'd0, WAIT_MAX - 1, 0, 1'b0, dead);
    check("late_ready_no_trap", trap, 0);

    do_reset();
    run_insn(6'b010101, 6'd0, 0, 0, 1'b0, dead);
    check("illegal_op_trap", trap, 1);
    do_reset();
    run_insn(O_R, 6'b000111, 0, 0, 1'b0, dead);
    check("illegal_fn_trap", trap, 1);

    do_reset();
    run_insn(O_HALT, 6'd0, 0, 0, 1'b0, dead);
    check("halt_flag", halted, 1'b1);
    check("halt_cycle_frozen", cycle_count, 2);
    check("halt_inst", inst_count, 1);

    do_reset();
    opcode = O_SW;
    step(T_FETCH, 1'b1, 1'b0, 1'b0, B_IMREQ | B_PCW | B_IRW, 1'b0);
    step(T_DECODE, 1'b0, 1'b0, 1'b0, sel(2'd0, 2'd3, 2'd0, 4'd0) | B_RDW | B_AOW, 1'b0);
    step(T_MEM_ADDR, 1'b0, 1'b0, 1'b0, sel(2'd1, 2'd2, 2'd0, 4'd0) | B_AOW, 1'b0);
    for (int i = 0; i < 3; i++) step(T_MEM_WR, 1'b0, 1'b0, 1'b0, B_DMREQ | B_WE, 1'b0);
    check("sw_wait_req", dmem_req, 1'b1);
    do_reset();

    for (int n = 0; n < 500; n++) begin
      random_insn(1'b1, dead);
      if (dead || $urandom_range(0, 49) == 0) do_reset();
    end

    do_reset();
    for (int n = 0; n < 280; n++) random_insn(1'b0, dead);
    check("inst_saturated", inst_count, CMAX);
    check("cycle_saturated", cycle_count, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
